uart_byte_packer_256: RTL

//  Upstream stage of fifo256to8: packs the UART receiver's byte stream (picture data) into
//  256-bit words for the FIFO's write side. A single holding register decouples the

---
 rtl/uart_byte_packer_256.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_byte_packer_256.sv
// uart_byte_packer_256
// Packs a UART byte stream into BYTES_PER_WORD-byte words for a FIFO write port.
// The first byte of a word lands in the least-significant lane. A single holding
// register sits between the assembly register and the FIFO. This lets the
// unstallable byte stream keep filling the next word while the FIFO is full.
// A byte that arrives while both registers are full is dropped, and the sticky
// overflow flag is raised.
module uart_byte_packer_256 #(
    parameter int BYTES_PER_WORD = 32,
    parameter int CNT_W          = 6,
    localparam int W             = 8 * BYTES_PER_WORD
) (
    input  logic             sclk,
    input  logic             srst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             sof,
    input  logic             wr_ready,
    output logic             wren,
    output logic [W-1:0]     data256,
    output logic             hold_valid,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    // Assembly side: partial word, its fill count, and "full word waiting for the hold"
    logic [W-1:0]     asm_q, asm_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             asm_full_q, asm_full_d;

    // Holding register facing the FIFO
    logic [W-1:0]     hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;

    // Sticky lost-byte flag
    logic             overflow_q, overflow_d;

    // Working signals for the next-state logic
    logic             wren_c;
    logic             hold_free;
    logic [CNT_W-1:0] eff_cnt;
    logic             eff_full;
    logic             drop;
    logic [W-1:0]     lane_word;
    logic [W-1:0]     lane0_word;

    // Returns word w with byte b written into lane 'lane'
    function automatic logic [W-1:0] put_lane(input logic [W-1:0]     w,
                                              input logic [CNT_W-1:0] lane,
                                              input logic [7:0]       b);
        logic [W-1:0] r;
        r = w;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (lane == CNT_W'(k)) begin
                r[8*k +: 8] = b;
            end
        end
        return r;
    endfunction

    // Next-state logic: sof resync first, then either drain a blocked word or accept a byte
    always_comb begin
        wren_c     = hold_valid_q & wr_ready;
        hold_free  = ~hold_valid_q | wren_c;

        // sof discards the partial or blocked word before the incoming byte is considered,
        // so a byte in the sof cycle is simply the first byte of a fresh word
        eff_cnt    = sof ? '0 : byte_cnt_q;
        eff_full   = sof ? 1'b0 : asm_full_q;

        lane_word  = put_lane(asm_q, eff_cnt, rx_data);
        lane0_word = put_lane(asm_q, '0, rx_data);

        asm_d        = asm_q;
        byte_cnt_d   = eff_cnt;
        asm_full_d   = eff_full;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q & ~wren_c;
        drop         = 1'b0;

        if (eff_full) begin
            // A blocked word can only be waiting while the hold is busy, so a free
            // hold here always means the hold is being written this cycle
            if (wren_c) begin
                hold_d       = asm_q;
                hold_valid_d = 1'b1;
                asm_full_d   = 1'b0;
                byte_cnt_d   = '0;
                if (rx_valid) begin
                    asm_d      = lane0_word;
                    byte_cnt_d = ONE;
                end
            end else if (rx_valid) begin
                drop = 1'b1;
            end
        end else if (rx_valid) begin
            asm_d = lane_word;
            if (eff_cnt == LAST_LANE) begin
                if (hold_free) begin
                    hold_d       = lane_word;
                    hold_valid_d = 1'b1;
                    byte_cnt_d   = '0;
                end else begin
                    asm_full_d   = 1'b1;
                    byte_cnt_d   = LAST_LANE;
                end
            end else begin
                byte_cnt_d = eff_cnt + ONE;
            end
        end

        // A drop in the same cycle as a clear must leave the flag set
        overflow_d = drop ? 1'b1 : (overflow_q & ~clr_ovf);
    end

    // State registers; reset clears everything, including the data paths
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            asm_q        <= '0;
            byte_cnt_q   <= '0;
            asm_full_q   <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_full_q   <= asm_full_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wren       = wren_c;
    assign data256    = hold_q;
    assign hold_valid = hold_valid_q;
    assign byte_cnt   = byte_cnt_q;
    assign overflow   = overflow_q;

endmodule
